// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and constants for the I2C request arbiter and its clients.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package i2c_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int ADDR_W_DEF = 16;

    // RTC time-keeping registers, seconds through year
    localparam logic [ADDR_W_DEF-1:0] RTC_SEC   = 16'h0002;
    localparam logic [ADDR_W_DEF-1:0] RTC_MIN   = 16'h0003;
    localparam logic [ADDR_W_DEF-1:0] RTC_HOUR  = 16'h0004;
    localparam logic [ADDR_W_DEF-1:0] RTC_DAY   = 16'h0005;
    localparam logic [ADDR_W_DEF-1:0] RTC_WDAY  = 16'h0006;
    localparam logic [ADDR_W_DEF-1:0] RTC_MONTH = 16'h0007;
    localparam logic [ADDR_W_DEF-1:0] RTC_YEAR  = 16'h0008;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Client request bundle plus I2C master command bus around the arbiter.
// Latency: wires only.
// Backpressure: req is a level held until done; master end is a pulse.
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_rd;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*8-1:0]      req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [7:0]                rdata;
    logic                      err;
    logic                      wr_en;
    logic                      rd_en;
    logic                      i2c_start;
    logic [ADDR_W-1:0]         byte_addr;
    logic [7:0]                wr_data;
    logic                      i2c_end;
    logic [7:0]                rd_data;

    // arbiter view
    modport slave (
        input  req, req_rd, req_addr, req_wdata, i2c_end, rd_data,
        output gnt, done, rdata, err, wr_en, rd_en, i2c_start, byte_addr, wr_data
    );

    // clients and I2C master view
    modport master (
        output req, req_rd, req_addr, req_wdata, i2c_end, rd_data,
        input  gnt, done, rdata, err, wr_en, rd_en, i2c_start, byte_addr, wr_data
    );
endinterface

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Round-robin picker: first set request after 'last', wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);

    always_comb begin
        idx    = '0;
        onehot = '0;
        any    = 1'b0;
        // walk from farthest to nearest so the nearest candidate wins
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                idx = IDX_W'((int'(last) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
        if (any) begin
            onehot = NUM_REQ'(1) << idx;
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin share of one byte-wide I2C master; optional watchdog via I2C_ARB_TIMEOUT_EN.
// Latency: req in IDLE -> i2c_start next cycle; i2c_end -> done next cycle.
// Backpressure: clients hold req until done; BUSY waits on i2c_end (or watchdog).
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    i2c_req_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_q;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   pick_oh;
    logic                 pick_any;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [7:0]           rdata_q;
    logic                 wr_en_q;
    logic                 rd_en_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [7:0]           wdata_q;
    logic                 start_c;
    logic [NUM_REQ-1:0]   done_c;
    logic                 to_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .last   (last_q),
        .idx    (pick_idx),
        .onehot (pick_oh),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        done_c    = '0;
        unique case (state)
            IDLE:  if (pick_any) state_nxt = START;
            START: begin
                start_c   = 1'b1;
                state_nxt = BUSY;
            end
            BUSY:  if (bus.i2c_end || to_hit) state_nxt = DONE;
            DONE:  begin
                done_c    = gnt_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            gnt_q   <= '0;
            rdata_q <= '0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        idx_q   <= pick_idx;
                        gnt_q   <= pick_oh;
                        addr_q  <= bus.req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        wdata_q <= bus.req_wdata[int'(pick_idx)*8 +: 8];
                        wr_en_q <= ~bus.req_rd[pick_idx];
                        rd_en_q <= bus.req_rd[pick_idx];
                    end
                end
                BUSY: begin
                    if (bus.i2c_end) begin
                        if (rd_en_q) rdata_q <= bus.rd_data;
                        last_q <= idx_q;
                    end else if (to_hit) begin
                        last_q <= idx_q;
                    end
                end
                DONE: begin
                    gnt_q   <= '0;
                    wr_en_q <= 1'b0;
                    rd_en_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        err_q;

    assign to_hit = (state == BUSY) && !bus.i2c_end && (to_cnt == 32'(TIMEOUT_CYC - 1));

    // err stays up across idle time; only a real i2c_end clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == BUSY) ? to_cnt + 32'd1 : 32'd0;
            if (state == BUSY && bus.i2c_end) begin
                err_q <= 1'b0;
            end else if (to_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.err = err_q;
`else
    assign to_hit  = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_c;
    assign bus.rdata     = rdata_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.i2c_start = start_c;
    assign bus.byte_addr = addr_q;
    assign bus.wr_data   = wdata_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: directed requests, queued expectations, negedge monitors.
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_req_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

    i2c_req_arbiter #(
        .NUM_REQ     (NR),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int          client;
        bit          rd;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          err;
        int          start_cyc;
        bit          b2b;
        bit          timeout;
    } exp_t;

    exp_t start_q[$];
    exp_t done_q[$];
    exp_t cur;
    exp_t se;
    exp_t de;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int rst_events = 0;
    int mdelay = 1;
    logic [7:0] mdata [NR];
    int last_end_cyc = 0;
    int last_done_cyc = 0;
    int start_cyc_rec = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int flight_bad = 0;
    int onehot_bad = 0;
    bit in_flight = 1'b0;
    logic [7:0] exp_rdata = 8'h00;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rst) rst_events <= rst_events + 1;

    // I2C master model: pulses i2c_end mdelay cycles after start, unless reset intervened
    initial begin
        int gen, c, d;
        bus.i2c_end = 1'b0;
        bus.rd_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.i2c_start === 1'b1 && mdelay >= 0) begin
                gen = rst_events;
                d   = mdelay;
                c   = 0;
                for (int i = 0; i < NR; i++) if (bus.gnt[i]) c = i;
                repeat (d) @(posedge clk);
                #1;
                if (gen == rst_events) begin
                    bus.rd_data  = mdata[c];
                    bus.i2c_end  = 1'b1;
                    last_end_cyc = cyc;
                    @(posedge clk);
                    #1;
                    bus.i2c_end = 1'b0;
                end
            end
        end
    end

    // monitor: start side and done side of every transaction
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight  = 1'b0;
                flight_bad = 0;
            end else begin
                if ($countones(bus.gnt) > 1) onehot_bad++;
                if (bus.i2c_start) begin
                    chk("start_expected", 32'(start_q.size() > 0), 32'd1);
                    if (start_q.size() > 0) begin
                        se = start_q.pop_front();
                        chk("start_gnt", 32'(bus.gnt), 32'(1 << se.client));
                        chk("start_addr", 32'(bus.byte_addr), 32'(se.addr));
                        chk("start_wr_en", 32'(bus.wr_en), 32'(!se.rd));
                        chk("start_rd_en", 32'(bus.rd_en), 32'(se.rd));
                        chk("start_wr_data", 32'(bus.wr_data), 32'(se.wdata));
                        if (se.start_cyc >= 0) chk("start_latency", cyc, se.start_cyc);
                        if (se.b2b) chk("b2b_latency", cyc, last_done_cyc + 2);
                        cur = se;
                        in_flight = 1'b1;
                        start_cyc_rec = cyc;
                    end
                    start_cnt++;
                end else if (in_flight && bus.gnt != '0) begin
                    if (bus.wr_en !== !cur.rd || bus.rd_en !== cur.rd || bus.byte_addr !== cur.addr)
                        flight_bad++;
                end
                if (bus.done != '0) begin
                    chk("done_expected", 32'(done_q.size() > 0), 32'd1);
                    if (done_q.size() > 0) begin
                        de = done_q.pop_front();
                        chk("done_onehot", 32'(bus.done), 32'(1 << de.client));
                        chk("done_gnt", 32'(bus.gnt), 32'(bus.done));
                        chk("done_rdata", 32'(bus.rdata), 32'(de.rdata));
                        chk("done_err", 32'(bus.err), 32'(de.err));
                        if (de.timeout) chk("timeout_latency", cyc, start_cyc_rec + TO + 1);
                        else            chk("done_latency", cyc, last_end_cyc + 1);
                        chk("cmd_stable", flight_bad, 0);
                    end
                    flight_bad = 0;
                    in_flight  = 1'b0;
                    done_cnt++;
                    last_done_cyc = cyc;
                end
            end
        end
    end

    task automatic push(input int c, input bit rd, input logic [15:0] a, input logic [7:0] w,
                        input int sc, input bit b2b, input bit to, input bit no_done);
        exp_t e;
        if (rd && !to && !no_done) exp_rdata = mdata[c];
        e.client = c; e.rd = rd; e.addr = a; e.wdata = w; e.rdata = exp_rdata;
        e.err = to; e.start_cyc = sc; e.b2b = b2b; e.timeout = to;
        start_q.push_back(e);
        if (!no_done) done_q.push_back(e);
    endtask

    task automatic drive(input int c, input bit rd, input logic [15:0] a, input logic [7:0] w);
        bus.req_rd[c] = rd;
        bus.req_addr[c*AW +: AW] = a;
        bus.req_wdata[c*8 +: 8] = w;
        bus.req[c] = 1'b1;
    endtask

    task automatic wait_start(input int n);
        int b = 0;
        while (start_cnt < n && b < 3000) begin @(negedge clk); #1; b++; end
        if (start_cnt < n) chk("wait_start_timeout", start_cnt, n);
    endtask

    task automatic wait_done(input int n);
        int b = 0;
        while (done_cnt < n && b < 3000) begin @(negedge clk); #1; b++; end
        if (done_cnt < n) chk("wait_done_timeout", done_cnt, n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
        chk({tag, "_i2c_start"}, 32'(bus.i2c_start), 32'd0);
        chk({tag, "_byte_addr"}, 32'(bus.byte_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req = '0; bus.req_rd = '0; bus.req_addr = '0; bus.req_wdata = '0;
        for (int i = 0; i < NR; i++) mdata[i] = 8'h00;
        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;

        // single write, client 0, end after 20 cycles
        tick();
        mdelay = 20;
        push(0, 1'b0, RTC_SEC, 8'h00, cyc + 1, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, RTC_SEC, 8'h00);
        wait_done(1);
        tick();
        bus.req[0] = 1'b0;

        // single read, client 2
        tick();
        mdelay = 7;
        mdata[2] = 8'h20;
        push(2, 1'b1, RTC_YEAR, 8'h00, cyc + 1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b1, RTC_YEAR, 8'h00);
        wait_done(2);
        tick();
        bus.req[2] = 1'b0;
        repeat (5) @(negedge clk);
        chk("rdata_hold", 32'(bus.rdata), 32'h20);

        // round robin from reset with all four clients requesting, i2c_end on first BUSY cycle
        tick();
        rst = 1'b1;
        exp_rdata = 8'h00;
        mdelay = 1;
        mdata[1] = 8'h11;
        mdata[3] = 8'h33;
        drive(0, 1'b0, RTC_MIN,  8'hA0);
        drive(1, 1'b1, RTC_HOUR, 8'h00);
        drive(2, 1'b0, RTC_DAY,  8'hA2);
        drive(3, 1'b1, RTC_WDAY, 8'h00);
        repeat (2) tick();
        push(0, 1'b0, RTC_MIN,  8'hA0, cyc + 1, 1'b0, 1'b0, 1'b0);
        push(1, 1'b1, RTC_HOUR, 8'h00, -1, 1'b1, 1'b0, 1'b0);
        push(2, 1'b0, RTC_DAY,  8'hA2, -1, 1'b1, 1'b0, 1'b0);
        push(3, 1'b1, RTC_WDAY, 8'h00, -1, 1'b1, 1'b0, 1'b0);
        push(0, 1'b0, RTC_MIN,  8'hA0, -1, 1'b1, 1'b0, 1'b0);
        n = start_cnt;
        rst = 1'b0;
        wait_start(n + 5);
        tick();
        bus.req = '0;
        wait_done(done_cnt + 1);

        // client 1 drops req while BUSY
        tick();
        mdelay = 10;
        push(1, 1'b0, RTC_MONTH, 8'h5A, cyc + 1, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, RTC_MONTH, 8'h5A);
        n = done_cnt;
        wait_start(start_cnt + 1);
        repeat (3) tick();
        bus.req[1] = 1'b0;
        wait_done(n + 1);

        // reset mid-transaction: no done, pointer back to client 3 so client 0 wins
        tick();
        mdelay = 30;
        mdata[3] = 8'h77;
        push(3, 1'b1, RTC_SEC, 8'h00, cyc + 1, 1'b0, 1'b0, 1'b1);
        drive(3, 1'b1, RTC_SEC, 8'h00);
        wait_start(start_cnt + 1);
        repeat (5) tick();
        rst = 1'b1;
        bus.req[3] = 1'b0;
        exp_rdata = 8'h00;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        n = done_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", done_cnt, n);
        tick();
        mdelay = 2;
        push(0, 1'b0, RTC_HOUR, 8'hC0, cyc + 1, 1'b0, 1'b0, 1'b0);
        push(2, 1'b0, RTC_DAY,  8'hC2, -1, 1'b1, 1'b0, 1'b0);
        drive(2, 1'b0, RTC_DAY,  8'hC2);
        drive(0, 1'b0, RTC_HOUR, 8'hC0);
        n = start_cnt;
        wait_start(n + 1);
        tick();
        bus.req[0] = 1'b0;
        wait_start(n + 2);
        tick();
        bus.req[2] = 1'b0;
        wait_done(done_cnt + 1);

        // single requester re-granted back-to-back
        tick();
        mdelay = 3;
        push(3, 1'b0, RTC_YEAR, 8'h99, cyc + 1, 1'b0, 1'b0, 1'b0);
        push(3, 1'b0, RTC_YEAR, 8'h99, -1, 1'b1, 1'b0, 1'b0);
        drive(3, 1'b0, RTC_YEAR, 8'h99);
        n = done_cnt;
        wait_start(start_cnt + 2);
        tick();
        bus.req[3] = 1'b0;
        wait_done(n + 2);

`ifdef I2C_ARB_TIMEOUT_EN
        // watchdog: master never answers
        tick();
        mdelay = -1;
        push(0, 1'b0, RTC_MIN, 8'h01, cyc + 1, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, RTC_MIN, 8'h01);
        n = done_cnt;
        wait_done(n + 1);
        tick();
        bus.req[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("err_sticky", 32'(bus.err), 32'd1);
        tick();
        mdelay = 2;
        push(1, 1'b0, RTC_SEC, 8'h02, cyc + 1, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, RTC_SEC, 8'h02);
        wait_done(n + 2);
        tick();
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_cleared", 32'(bus.err), 32'd0);
`endif

        repeat (10) @(negedge clk);
        chk("start_q_drained", start_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("gnt_onehot", onehot_bad, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Shares the single byte-oriented I2C master between NUM_REQ clients, such as the RTC time controller, EEPROM loader and sensor poller.
- Each client posts a one-byte read or write request. The arbiter grants one client at a time in round-robin order and drives the master's command interface.
- On completion it waits for i2c_end, then returns read data and a done pulse to the granted client.
- It sits between the clients and the I2C master. It runs on the master's clock, so no CDC is involved.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8).
- ADDR_W, 16, width of byte_addr.
- TIMEOUT_CYC, 65535, watchdog limit in clk cycles. Used only with I2C_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; same clock as the I2C master.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-client request level.
- req_rd  in  NUM_REQ  per-client direction: 1 = read, 0 = write.
- req_addr  in  NUM_REQ*ADDR_W  per-client byte address, flattened; client i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*8  per-client write byte, flattened.
- gnt  out  NUM_REQ  one-hot, high while a client's transaction is in flight.
- done  out  NUM_REQ  one-cycle completion pulse to the granted client.
- rdata  out  8  captured read byte; valid in the done cycle and held until the next capture.
- err  out  1  timeout flag; constant 0 without the macro.
- wr_en  out  1  to master: write command.
- rd_en  out  1  to master: read command.
- i2c_start  out  1  to master: start pulse.
- byte_addr  out  ADDR_W  to master.
- wr_data  out  8  to master.
- i2c_end  in  1  from master: one-cycle end-of-transaction pulse.
- rd_data  in  8  from master: valid when i2c_end = 1.

Behaviour:
- Reset (rst = 1 at a clk edge):
  - state = IDLE; all outputs 0; round-robin pointer last = NUM_REQ-1.
  - A transaction in flight is dropped with no done pulse. The master is assumed reset alongside.
- States: IDLE, START, BUSY, DONE.
- IDLE:
  - If req != 0, select the first set bit scanning from last+1, wrapping modulo NUM_REQ.
  - Register the index, gnt one-hot, byte_addr, wr_data, and wr_en = ~req_rd[i], rd_en = req_rd[i]. Go to START.
  - If req == 0, stay in IDLE; command outputs hold their last values; wr_en = rd_en = 0.
- START: i2c_start = 1 for exactly this cycle; go to BUSY.
- BUSY:
  - i2c_start = 0; command outputs held stable.
  - On i2c_end = 1: rdata <= rd_data (read transactions only; a write leaves rdata unchanged), last <= granted index, go to DONE.
- DONE:
  - done[i] = 1 for this cycle; gnt is still asserted.
  - Next cycle: gnt = 0, wr_en = rd_en = 0, state = IDLE.
- Latency:
  - req sampled in IDLE at cycle N gives i2c_start = 1 at cycle N+1.
  - i2c_end at cycle M gives done at cycle M+1; the earliest next i2c_start is at M+3.
- Client rules:
  - Fields must stay stable while req is high and until done.
  - Dropping req after grant does not abort; done still pulses.
  - A client holding req after done is re-arbitrated, so other pending clients are served first.
- Boundaries:
  - i2c_end outside BUSY is ignored.
  - i2c_end in the same cycle as entering BUSY is accepted.
  - Simultaneous requests are resolved purely by round-robin, with no fixed priority.
  - A single requester is re-granted back-to-back.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in BUSY. If it reaches TIMEOUT_CYC without i2c_end, go to DONE with done[i] pulsed, rdata unchanged, and err set.
  - err is sticky until reset or the next successful completion.
- Without the macro: no counter; err is tied to 0; BUSY waits indefinitely.

Decomposition:
- Package i2c_arb_pkg holds:
  - the state enum (IDLE/START/BUSY/DONE), 2 bits;
  - the default ADDR_W;
  - the register address constants for RTC seconds..year (0x02-0x08) used by clients.
- Sub-module rr_pick (combinational):
  - inputs: req vector, last index;
  - outputs: grant index, one-hot grant, any.

Test Plan:
- Single write:
  - Stimulus: client 0 requests rd = 0, addr 0x0002, wdata 0x00; master returns i2c_end after 20 cycles.
  - Response: i2c_start at N+1; byte_addr = 0x0002, wr_en = 1 throughout; done[0] one cycle after i2c_end; rdata unchanged.
- Single read:
  - Stimulus: client 2 requests rd = 1, addr 0x0008; master returns rd_data = 0x20.
  - Response: rd_en = 1; rdata = 0x20 in the done[2] cycle and held afterwards.
- Round-robin:
  - Stimulus: all four clients hold req continuously from reset.
  - Response: grant order 0, 1, 2, 3, 0; exactly one done per grant; never two gnt bits high.
- Dropped req:
  - Stimulus: client 1 deasserts req in BUSY.
  - Response: the transaction completes and done[1] still pulses.
- Reset mid-transaction:
  - Stimulus: assert rst during BUSY.
  - Response: next cycle all outputs 0, state IDLE, no done pulse; a later request is granted starting from client 0.
- Timeout (macro on, TIMEOUT_CYC = 100):
  - Stimulus: master never pulses i2c_end.
  - Response: done[i] and err = 1 at 100 cycles into BUSY; err clears after the next good transaction.
